// File: rtl/rst_seq_ctrl.sv
// -----------------------------------------------------------------------------
// rst_seq_ctrl
//   Reset sequencer between the power-on reset generator and the gyro datapath.
//   Qualifies PLL lock, then releases N_STAGE active-low reset domains one at a
//   time (bit 0 first) with STAGE_DLY cycles between releases. In RELEASE/RUN a
//   lock loss, watchdog expiry or software request drops every domain, holds
//   them for HOLD_CYC cycles and restarts lock qualification.
//
// Ports
//   i_clk         system clock
//   i_rst_n       asynchronous active-low reset
//   i_pll_locked  PLL lock indicator (synchronous to i_clk)
//   i_wdt_expire  watchdog expiry level
//   i_sw_rst_req  software reset request
//   o_rst_n       per-domain active-low resets, bit 0 released first
//   o_busy        1 whenever not in RUN
//   o_cause       last reset cause: 0=POR, 1=lock loss, 2=SW, 3=WDT
//   o_rst_cnt     saturating count of run-time resets
// -----------------------------------------------------------------------------
module rst_seq_ctrl #(
   parameter int unsigned N_STAGE   = 4,
   parameter int unsigned STAGE_DLY = 250000,
   parameter int unsigned HOLD_CYC  = 2500,
   parameter int unsigned LOCK_FILT = 1000
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_pll_locked,
   input  logic               i_wdt_expire,
   input  logic               i_sw_rst_req,
   output logic [N_STAGE-1:0] o_rst_n,
   output logic               o_busy,
   output logic [1:0]         o_cause,
   output logic [7:0]         o_rst_cnt
);

   localparam logic [1:0] S_WAIT_LOCK = 2'd0;
   localparam logic [1:0] S_RELEASE   = 2'd1;
   localparam logic [1:0] S_RUN       = 2'd2;
   localparam logic [1:0] S_ASSERT    = 2'd3;

   localparam logic [1:0] C_POR  = 2'd0;
   localparam logic [1:0] C_LOCK = 2'd1;
   localparam logic [1:0] C_SW   = 2'd2;
   localparam logic [1:0] C_WDT  = 2'd3;

   // Counters only need to reach PARAM-1; keep at least one bit.
   localparam int unsigned LW = (LOCK_FILT > 1) ? $clog2(LOCK_FILT) : 1;
   localparam int unsigned DW = (STAGE_DLY > 1) ? $clog2(STAGE_DLY) : 1;
   localparam int unsigned HW = (HOLD_CYC  > 1) ? $clog2(HOLD_CYC)  : 1;
   localparam int unsigned IW = (N_STAGE   > 1) ? $clog2(N_STAGE)   : 1;

   localparam logic [LW-1:0] LOCK_LAST  = LW'(LOCK_FILT - 1);
   localparam logic [DW-1:0] DLY_LAST   = DW'(STAGE_DLY - 1);
   localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_CYC - 1);
   localparam logic [IW-1:0] STAGE_LAST = IW'(N_STAGE - 1);

   logic [1:0]         state_q, state_d;
   logic [LW-1:0]      lock_cnt_q, lock_cnt_d;
   logic [DW-1:0]      dly_cnt_q, dly_cnt_d;
   logic [HW-1:0]      hold_cnt_q, hold_cnt_d;
   logic [IW-1:0]      idx_q, idx_d;
   logic [N_STAGE-1:0] rst_n_q, rst_n_d;
   logic               busy_q, busy_d;
   logic [1:0]         cause_q, cause_d;
   logic [7:0]         cnt_q, cnt_d;

   logic               req;
   logic [1:0]         req_cause;

   assign req = ~i_pll_locked | i_wdt_expire | i_sw_rst_req;

   // Priority: lock loss > watchdog > software.
   always_comb begin
      req_cause = C_SW;
      if (!i_pll_locked) begin
         req_cause = C_LOCK;
      end else if (i_wdt_expire) begin
         req_cause = C_WDT;
      end
   end

   always_comb begin
      state_d    = state_q;
      lock_cnt_d = lock_cnt_q;
      dly_cnt_d  = dly_cnt_q;
      hold_cnt_d = hold_cnt_q;
      idx_d      = idx_q;
      rst_n_d    = rst_n_q;
      busy_d     = busy_q;
      cause_d    = cause_q;
      cnt_d      = cnt_q;

      case (state_q)
         S_WAIT_LOCK: begin
            if (!i_pll_locked) begin
               lock_cnt_d = '0;
            end else if (lock_cnt_q == LOCK_LAST) begin
               state_d    = S_RELEASE;
               lock_cnt_d = '0;
               dly_cnt_d  = '0;
               idx_d      = '0;
            end else begin
               lock_cnt_d = lock_cnt_q + 1'b1;
            end
         end

         S_RELEASE, S_RUN: begin
            // A request wins over a stage release falling in the same cycle.
            if (req) begin
               state_d    = S_ASSERT;
               rst_n_d    = '0;
               busy_d     = 1'b1;
               cause_d    = req_cause;
               cnt_d      = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
               hold_cnt_d = '0;
               dly_cnt_d  = '0;
               idx_d      = '0;
            end else if (state_q == S_RELEASE) begin
               if (dly_cnt_q == DLY_LAST) begin
                  rst_n_d[idx_q] = 1'b1;
                  dly_cnt_d      = '0;
                  if (idx_q == STAGE_LAST) begin
                     state_d = S_RUN;
                     busy_d  = 1'b0;
                  end else begin
                     idx_d = idx_q + 1'b1;
                  end
               end else begin
                  dly_cnt_d = dly_cnt_q + 1'b1;
               end
            end
         end

         S_ASSERT: begin
            if (hold_cnt_q == HOLD_LAST) begin
               state_d    = S_WAIT_LOCK;
               hold_cnt_d = '0;
               lock_cnt_d = '0;
            end else begin
               hold_cnt_d = hold_cnt_q + 1'b1;
            end
         end

         default: begin
            state_d = S_WAIT_LOCK;
            rst_n_d = '0;
            busy_d  = 1'b1;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= S_WAIT_LOCK;
         lock_cnt_q <= '0;
         dly_cnt_q  <= '0;
         hold_cnt_q <= '0;
         idx_q      <= '0;
         rst_n_q    <= '0;
         busy_q     <= 1'b1;
         cause_q    <= C_POR;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         lock_cnt_q <= lock_cnt_d;
         dly_cnt_q  <= dly_cnt_d;
         hold_cnt_q <= hold_cnt_d;
         idx_q      <= idx_d;
         rst_n_q    <= rst_n_d;
         busy_q     <= busy_d;
         cause_q    <= cause_d;
         cnt_q      <= cnt_d;
      end
   end

   assign o_rst_n   = rst_n_q;
   assign o_busy    = busy_q;
   assign o_cause   = cause_q;
   assign o_rst_cnt = cnt_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rst_seq_ctrl
//   Table of {inputs, cycles to advance, expected outputs} records applied in
//   order; each record's expectation is queued when its stimulus is driven and
//   popped for comparison once the cycles have elapsed. A monitor also checks
//   that o_rst_n is always a contiguous run of ones from bit 0.
// -----------------------------------------------------------------------------
module tb_rst_seq_ctrl;

   localparam int unsigned NS = 4;
   localparam int unsigned SD = 10;
   localparam int unsigned HC = 5;
   localparam int unsigned LF = 4;

   logic          clk   = 1'b0;
   logic          rst_n = 1'b0;
   logic          lock  = 1'b0;
   logic          wdt   = 1'b0;
   logic          sw    = 1'b0;
   logic [NS-1:0] rst_o;
   logic          busy;
   logic [1:0]    cause;
   logic [7:0]    cnt;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   rst_seq_ctrl #(
      .N_STAGE  (NS),
      .STAGE_DLY(SD),
      .HOLD_CYC (HC),
      .LOCK_FILT(LF)
   ) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_pll_locked(lock),
      .i_wdt_expire(wdt),
      .i_sw_rst_req(sw),
      .o_rst_n     (rst_o),
      .o_busy      (busy),
      .o_cause     (cause),
      .o_rst_cnt   (cnt)
   );

   typedef struct {
      string         name;
      logic          rst_n;
      logic          lock;
      logic          wdt;
      logic          sw;
      int unsigned   wait_cyc;
      logic [NS-1:0] e_rst;
      logic          e_busy;
      logic [1:0]    e_cause;
      logic [7:0]    e_cnt;
   } vec_t;

   vec_t tbl[$];
   vec_t sb[$];

   function automatic vec_t mk(string nm, logic r, logic l, logic w, logic s,
                               int unsigned n, logic [NS-1:0] er, logic eb,
                               logic [1:0] ec, logic [7:0] en);
      vec_t v;
      v.name = nm; v.rst_n = r; v.lock = l; v.wdt = w; v.sw = s;
      v.wait_cyc = n; v.e_rst = er; v.e_busy = eb; v.e_cause = ec; v.e_cnt = en;
      return v;
   endfunction

   task automatic chk(string nm, string fld, logic [31:0] act, logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s.%s: got %0h expected %0h (t=%0t)", nm, fld, act, exp, $time);
      end
   endtask

   // Legal patterns are 2^k-1: no released domain above an unreleased one.
   always @(negedge clk) begin
      if ($time > 20) begin
         n_tests++;
         if (((rst_o & (rst_o + 1'b1)) !== '0)) begin
            n_fail++;
            $display("FAIL order_inv: got %b expected contiguous ones from bit 0", rst_o);
         end
      end
   end

   initial begin
      vec_t v;
      vec_t e;
      //            name                rst lk wd sw  wait  rst_n  busy cause cnt
      // POR sequence
      tbl.push_back(mk("por_reset",       0, 1, 0, 0,    1, 4'b0000, 1, 0, 0));
      tbl.push_back(mk("por_no_early",    1, 1, 0, 0,   13, 4'b0000, 1, 0, 0));
      tbl.push_back(mk("por_stage0",      1, 1, 0, 0,    1, 4'b0001, 1, 0, 0));
      tbl.push_back(mk("por_stage0_hold", 1, 1, 0, 0,    9, 4'b0001, 1, 0, 0));
      tbl.push_back(mk("por_stage1",      1, 1, 0, 0,    1, 4'b0011, 1, 0, 0));
      tbl.push_back(mk("por_stage2",      1, 1, 0, 0,   10, 4'b0111, 1, 0, 0));
      tbl.push_back(mk("por_pre_run",     1, 1, 0, 0,    9, 4'b0111, 1, 0, 0));
      tbl.push_back(mk("por_run",         1, 1, 0, 0,    1, 4'b1111, 0, 0, 0));
      tbl.push_back(mk("run_hold",        1, 1, 0, 0,    5, 4'b1111, 0, 0, 0));
      // Watchdog pulse in RUN: hold 5 + qualify 4 + stage 10 -> bit0 19 later
      tbl.push_back(mk("wdt_assert",      1, 1, 1, 0,    1, 4'b0000, 1, 3, 1));
      tbl.push_back(mk("wdt_requal",      1, 1, 0, 0,   18, 4'b0000, 1, 3, 1));
      tbl.push_back(mk("wdt_stage0",      1, 1, 0, 0,    1, 4'b0001, 1, 3, 1));
      tbl.push_back(mk("wdt_pre_run",     1, 1, 0, 0,   29, 4'b0111, 1, 3, 1));
      tbl.push_back(mk("wdt_run",         1, 1, 0, 0,    1, 4'b1111, 0, 3, 1));
      // Simultaneous requests: lock loss wins, single increment
      tbl.push_back(mk("multi_req",       1, 0, 1, 1,    1, 4'b0000, 1, 1, 2));
      // Abort during RELEASE at 0011
      tbl.push_back(mk("abort_pre",       1, 1, 0, 0,   29, 4'b0011, 1, 1, 2));
      tbl.push_back(mk("abort_sw",        1, 1, 0, 1,    1, 4'b0000, 1, 2, 3));
      tbl.push_back(mk("assert_ignore",   1, 1, 1, 1,    5, 4'b0000, 1, 2, 3));
      tbl.push_back(mk("waitlock_ignore", 1, 1, 1, 1,    4, 4'b0000, 1, 2, 3));
      tbl.push_back(mk("release_req",     1, 1, 1, 1,    1, 4'b0000, 1, 3, 4));
      // Saturation: a held SW request re-fires every 10 cycles
      tbl.push_back(mk("sat_254",         1, 1, 0, 1, 2509, 4'b0000, 1, 2, 254));
      tbl.push_back(mk("sat_255",         1, 1, 0, 1,    1, 4'b0000, 1, 2, 255));
      tbl.push_back(mk("sat_hold",        1, 1, 0, 1,  100, 4'b0000, 1, 2, 255));
      tbl.push_back(mk("sat_release",     1, 1, 0, 0,   29, 4'b0011, 1, 2, 255));
      // Async reset mid-RELEASE, checked 1 time unit later without a clock edge
      tbl.push_back(mk("async_reset",     0, 1, 0, 0,    0, 4'b0000, 1, 0, 0));
      tbl.push_back(mk("reset_held",      0, 1, 0, 0,    2, 4'b0000, 1, 0, 0));
      // Lock glitch restarts qualification
      tbl.push_back(mk("glitch_pre",      1, 1, 0, 0,    3, 4'b0000, 1, 0, 0));
      tbl.push_back(mk("glitch_low",      1, 0, 0, 0,    1, 4'b0000, 1, 0, 0));
      tbl.push_back(mk("glitch_no_early", 1, 1, 0, 0,   13, 4'b0000, 1, 0, 0));
      tbl.push_back(mk("glitch_stage0",   1, 1, 0, 0,    1, 4'b0001, 1, 0, 0));
      // Single-cycle lock loss in RELEASE
      tbl.push_back(mk("release_lockloss",1, 0, 0, 0,    1, 4'b0000, 1, 1, 1));

      repeat (3) @(posedge clk);
      #1;

      foreach (tbl[i]) begin
         v     = tbl[i];
         rst_n = v.rst_n;
         lock  = v.lock;
         wdt   = v.wdt;
         sw    = v.sw;
         sb.push_back(v);
         if (v.wait_cyc == 0) begin
            #1;
         end else begin
            repeat (v.wait_cyc) @(posedge clk);
            #1;
         end
         e = sb.pop_front();
         chk(e.name, "rst_n", 32'(rst_o), 32'(e.e_rst));
         chk(e.name, "busy",  32'(busy),  32'(e.e_busy));
         chk(e.name, "cause", 32'(cause), 32'(e.e_cause));
         chk(e.name, "cnt",   32'(cnt),   32'(e.e_cnt));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/rst_seq_ctrl.md
Name: rst_seq_ctrl

Overview:
Reset sequencer that sits between the power-on reset generator and the gyro datapath blocks. It qualifies PLL lock, then releases N_STAGE active-low reset domains one at a time, in index order, with a programmable gap between stages. At run time it re-asserts all domains on PLL lock loss, watchdog expiry or a software reset request. It records the cause and keeps a saturating count of run-time resets.

Parameters:
N_STAGE, 4, number of sequenced reset domains (>=1)
STAGE_DLY, 250000, cycles between successive stage releases (5 ms at 50 MHz; >=1)
HOLD_CYC, 2500, minimum cycles all domains are held in reset after a run-time request (>=1)
LOCK_FILT, 1000, consecutive i_pll_locked=1 cycles required to qualify lock (>=1)

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  asynchronous active-low reset (driven by the power-on reset generator)
i_pll_locked  in  1  PLL lock indicator, synchronous to i_clk
i_wdt_expire  in  1  watchdog expiry, level, sampled each cycle
i_sw_rst_req  in  1  software reset request, sampled each cycle
o_rst_n  out  N_STAGE  per-domain active-low resets; bit 0 is released first
o_busy  out  1  1 whenever not in RUN
o_cause  out  2  last reset cause: 0=POR, 1=lock loss, 2=SW, 3=WDT
o_rst_cnt  out  8  count of run-time resets, saturates at 255

Behaviour:
- Async reset (i_rst_n=0):
  - o_rst_n=0 (all bits), o_busy=1, o_cause=0, o_rst_cnt=0.
  - State=WAIT_LOCK; lock filter, delay and stage counters cleared.
- All outputs are registered. Counter widths are sized with $clog2 of their parameters.
- WAIT_LOCK:
  - Lock counter increments while i_pll_locked=1 and clears to 0 on any i_pll_locked=0.
  - After LOCK_FILT consecutive high cycles -> RELEASE, stage index=0, delay counter=0.
  - i_wdt_expire and i_sw_rst_req are ignored.
- RELEASE:
  - Delay counter counts each cycle.
  - On the cycle it equals STAGE_DLY-1: set o_rst_n[idx]=1, idx+1, delay counter=0.
  - Stage k rises STAGE_DLY*(k+1) cycles after RELEASE entry.
  - After bit N_STAGE-1 is set -> RUN; o_busy=0 in the same cycle o_rst_n becomes all ones.
- RUN: holds all o_rst_n=1 and o_busy=0.
- Request detection (RELEASE or RUN only):
  - Lock loss (i_pll_locked=0 for any single cycle), i_wdt_expire=1 or i_sw_rst_req=1 -> ASSERT.
  - Cycle after detection: o_rst_n=0 (all bits), o_busy=1, o_cause updated, o_rst_cnt+1 (saturating at 255).
  - A request during RELEASE aborts the sequence. Partially released bits drop together.
- Simultaneous requests: priority lock loss > WDT > SW. Only one cause is recorded and o_rst_cnt increments once.
- ASSERT:
  - Holds all resets low for exactly HOLD_CYC cycles, then -> WAIT_LOCK with the lock counter cleared.
  - Requests are ignored; o_cause and o_rst_cnt stay frozen.
  - A request still active on WAIT_LOCK entry is ignored until RELEASE.
- Invariant: o_rst_n[k]=1 implies o_rst_n[j]=1 for all j<k. No other bit pattern is legal.
- i_rst_n asserted mid-sequence or in RUN: immediate return to reset values, including o_cause=0 and o_rst_cnt=0.

Test Plan:
(Bench params: N_STAGE=4, STAGE_DLY=10, HOLD_CYC=5, LOCK_FILT=4.)
1. POR: release i_rst_n with i_pll_locked=1 -> RELEASE entered 4 cycles later. o_rst_n steps 0001, 0011, 0111, 1111 at +10, +20, +30, +40 cycles. o_busy falls with 1111; o_cause=0.
2. Lock glitch: locked 3 cycles, low 1 cycle, then high -> lock counter restarts; RELEASE entered 4 cycles after the re-rise. No early stage release.
3. Watchdog in RUN: 1-cycle i_wdt_expire -> next cycle o_rst_n=0000, o_cause=3, o_rst_cnt=1. Exactly 5 cycles low, then 4-cycle lock qualify and full re-sequence.
4. Simultaneous requests: i_sw_rst_req, i_wdt_expire and i_pll_locked=0 in one RUN cycle -> o_cause=1, o_rst_cnt increments by exactly 1.
5. Abort during RELEASE: i_sw_rst_req when o_rst_n=0011 -> next cycle 0000, o_cause=2. Further requests during ASSERT leave o_rst_cnt unchanged.
6. Saturation and reset: 260 SW requests -> o_rst_cnt stops at 255. Assert i_rst_n mid-RELEASE -> all outputs return to reset values immediately.
